// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared forwarding encodings and control-bundle layout for the pipeline registers
package pipe_pkg;

  localparam int CTRL_W = 9;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  // Bit positions inside the packed control bundle
  localparam int CTRL_REG_WRITE  = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 4;

  localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/stage_reg.sv
// rtl/stage_reg.sv - width-parameterised stage register with hold and synchronous bubble clear
module stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Clear outranks enable so a bubble can be forced into a stage that would otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_regs.sv
// rtl/pipe_regs.sv - IF/ID, ID/EX, EX/MEM, MEM/WB register bank with stall, flush and EX operand forwarding
module pipe_regs #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [31:0]       if_instr,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic [AW-1:0]     id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_en,
  output logic [DATA_W-1:0] ifid_pc,
  output logic [31:0]       ifid_instr,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [AW-1:0]     mem_rd,
  output logic              mem_reg_write,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [AW-1:0]     wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data
);

  import pipe_pkg::*;

  localparam int IFID_W  = 1 + DATA_W + 32;
  localparam int IDEX_W  = 3 * AW + 3 * DATA_W + CTRL_W;
  localparam int EXMEM_W = AW + CTRL_W + 2 * DATA_W;
  localparam int MEMWB_W = AW + 2 + 2 * DATA_W;

  logic [IFID_W-1:0]  w_ifid_d,  w_ifid_q;
  logic [IDEX_W-1:0]  w_idex_d,  w_idex_q;
  logic [EXMEM_W-1:0] w_exmem_d, w_exmem_q;
  logic [MEMWB_W-1:0] w_memwb_d, w_memwb_q;

  logic              w_ifid_valid;
  logic [CTRL_W-1:0] w_id_ctrl;
  logic [DATA_W-1:0] w_ex_rs_data, w_ex_rt_data, w_ex_imm;
  logic [DATA_W-1:0] w_fwd_a, w_fwd_b;
  logic              w_wb_mem_to_reg;
  logic [DATA_W-1:0] w_wb_alu, w_wb_rdata;

  // A flush must let the PC take the redirect even while the hazard unit asks for a stall
  assign pc_en = flush | ~stall;

  assign w_ifid_d = {1'b1, if_pc, if_instr};
  assign {w_ifid_valid, ifid_pc, ifid_instr} = w_ifid_q;

  stage_reg #(.W(IFID_W)) u_ifid (
    .clk(clk), .reset_n(reset_n), .en(pc_en), .clr(flush),
    .d(w_ifid_d), .q(w_ifid_q)
  );

  // An empty IF/ID slot (after reset or flush) decodes to no side effects
  assign w_id_ctrl = w_ifid_valid ? id_ctrl : CTRL_W'(BUBBLE);
  assign w_idex_d  = {id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, w_id_ctrl};
  assign {ex_rs, ex_rt, ex_rd, w_ex_rs_data, w_ex_rt_data, w_ex_imm, ex_ctrl} = w_idex_q;

  stage_reg #(.W(IDEX_W)) u_idex (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(stall | flush),
    .d(w_idex_d), .q(w_idex_q)
  );

  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] wb_val
  );
    case (sel)
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return reg_val;
    endcase
  endfunction

  assign w_fwd_a       = fwd_pick(fwd_a, w_ex_rs_data, mem_alu_result, wb_data);
  assign w_fwd_b       = fwd_pick(fwd_b, w_ex_rt_data, mem_alu_result, wb_data);
  assign ex_op_a       = w_fwd_a;
  assign ex_store_data = w_fwd_b;
  assign ex_op_b       = ex_ctrl[CTRL_ALU_SRC] ? w_ex_imm : w_fwd_b;

  assign w_exmem_d = {ex_rd, ex_ctrl, ex_alu_result, ex_store_data};
  assign {mem_rd, mem_ctrl, mem_alu_result, mem_store_data} = w_exmem_q;
  assign mem_reg_write = mem_ctrl[CTRL_REG_WRITE];

  stage_reg #(.W(EXMEM_W)) u_exmem (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(1'b0),
    .d(w_exmem_d), .q(w_exmem_q)
  );

  assign w_memwb_d = {mem_rd, mem_reg_write, mem_ctrl[CTRL_MEM_TO_REG], mem_alu_result, mem_rdata};
  assign {wb_rd, wb_reg_write, w_wb_mem_to_reg, w_wb_alu, w_wb_rdata} = w_memwb_q;
  assign wb_data = w_wb_mem_to_reg ? w_wb_rdata : w_wb_alu;

  stage_reg #(.W(MEMWB_W)) u_memwb (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(1'b0),
    .d(w_memwb_d), .q(w_memwb_q)
  );

endmodule

// File: tb/tb_pipe_regs.sv
// tb/tb_pipe_regs.sv - self-checking bench for pipe_regs with an instruction-slot reference model
module tb_pipe_regs;

  localparam int DATA_W = 32;
  localparam int AW     = 5;
  localparam int CTRL_W = 9;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_USE  = 32'h0043_0820;
  localparam logic [31:0] I_BEQ  = 32'h1111_1111;
  localparam logic [31:0] I_ADDI = 32'h2242_0007;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] if_pc;
  logic [31:0]       if_instr;
  logic              stall, flush;
  logic [1:0]        fwd_a, fwd_b;
  logic [AW-1:0]     id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] ex_alu_result, mem_rdata;
  logic              pc_en;
  logic [DATA_W-1:0] ifid_pc;
  logic [31:0]       ifid_instr;
  logic [AW-1:0]     ex_rs, ex_rt, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_op_a, ex_op_b, ex_store_data;
  logic [AW-1:0]     mem_rd;
  logic              mem_reg_write;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [DATA_W-1:0] mem_alu_result, mem_store_data;
  logic [AW-1:0]     wb_rd;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_data;

  always #5 clk = ~clk;

  pipe_regs #(.DATA_W(DATA_W), .AW(AW), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .if_instr(if_instr),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_alu_result(ex_alu_result), .mem_rdata(mem_rdata),
    .pc_en(pc_en), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_ctrl(mem_ctrl),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data)
  );

  // One record per instruction in flight; fields fill in as it moves down the pipe
  typedef struct {
    logic        valid;
    logic [31:0] pc, instr;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [8:0]  ctrl;
    logic [31:0] alu, store, rdata;
  } slot_t;

  slot_t pipe [4];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wb_data();
    return pipe[3].ctrl[5] ? pipe[3].rdata : pipe[3].alu;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'b10) return pipe[2].alu;
    if (sel == 2'b01) return m_wb_data();
    return regv;
  endfunction

  function automatic logic [31:0] m_op_b();
    return pipe[1].ctrl[4] ? pipe[1].imm : m_fwd(fwd_b, pipe[1].rt_data);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) pipe[i] = '{default: '0};
  endtask

  task automatic model_advance();
    slot_t n0, n1, n2, n3;
    n3 = pipe[2];
    n3.rdata = mem_rdata;
    n2 = pipe[1];
    n2.alu = ex_alu_result;
    n2.store = m_fwd(fwd_b, pipe[1].rt_data);
    n1 = '{default: '0};
    if (!(stall || flush)) begin
      n1 = pipe[0];
      n1.rs = id_rs; n1.rt = id_rt; n1.rd = id_rd;
      n1.rs_data = id_rs_data; n1.rt_data = id_rt_data; n1.imm = id_imm;
      n1.ctrl = pipe[0].valid ? id_ctrl : 9'h0;
    end
    n0 = '{default: '0};
    if (!flush) begin
      if (stall) n0 = pipe[0];
      else begin n0.valid = 1'b1; n0.pc = if_pc; n0.instr = if_instr; end
    end
    pipe[0] = n0; pipe[1] = n1; pipe[2] = n2; pipe[3] = n3;
  endtask

  task automatic check_all();
    chk("pc_en",          32'(pc_en),          32'(flush || !stall));
    chk("ifid_pc",        ifid_pc,             pipe[0].pc);
    chk("ifid_instr",     ifid_instr,          pipe[0].instr);
    chk("ex_rs",          32'(ex_rs),          32'(pipe[1].rs));
    chk("ex_rt",          32'(ex_rt),          32'(pipe[1].rt));
    chk("ex_rd",          32'(ex_rd),          32'(pipe[1].rd));
    chk("ex_ctrl",        32'(ex_ctrl),        32'(pipe[1].ctrl));
    chk("ex_op_a",        ex_op_a,             m_fwd(fwd_a, pipe[1].rs_data));
    chk("ex_op_b",        ex_op_b,             m_op_b());
    chk("ex_store_data",  ex_store_data,       m_fwd(fwd_b, pipe[1].rt_data));
    chk("mem_rd",         32'(mem_rd),         32'(pipe[2].rd));
    chk("mem_reg_write",  32'(mem_reg_write),  32'(pipe[2].ctrl[8]));
    chk("mem_ctrl",       32'(mem_ctrl),       32'(pipe[2].ctrl));
    chk("mem_alu_result", mem_alu_result,      pipe[2].alu);
    chk("mem_store_data", mem_store_data,      pipe[2].store);
    chk("wb_rd",          32'(wb_rd),          32'(pipe[3].rd));
    chk("wb_reg_write",   32'(wb_reg_write),   32'(pipe[3].ctrl[8]));
    chk("wb_data",        wb_data,             m_wb_data());
  endtask

  task automatic idle();
    if_pc = '0; if_instr = '0; stall = 1'b0; flush = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
    id_rs = '0; id_rt = '0; id_rd = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_ctrl = '0; ex_alu_result = '0; mem_rdata = '0;
  endtask

  task automatic randomize_inputs();
    if_pc = $urandom; if_instr = $urandom;
    stall = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 5) == 0);
    fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_ctrl = 9'($urandom); ex_alu_result = $urandom; mem_rdata = $urandom;
  endtask

  // Check with the current inputs, then take one clock edge
  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    if (reset_n) model_advance();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_ifid_instr", ifid_instr, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    stall = 1'b0; flush = 1'b0;
    #1 reset_n = 1'b1;
    #1 chk("rst_pc_en", 32'(pc_en), 32'h1);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("init_pc_en", 32'(pc_en), 32'h1);

    repeat (20) begin randomize_inputs(); cyc(); end
    do_reset();

    // Straight-line add $3,$1,$2
    idle(); if_instr = I_ADD; if_pc = 32'h100; cyc();
    chk("add_ifid", ifid_instr, I_ADD);
    idle(); id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_rs_data = 32'd5; id_rt_data = 32'd7; id_ctrl = 9'h102; cyc();
    idle(); ex_alu_result = 32'd12; #1;
    chk("add_op_a", ex_op_a, 32'd5);
    chk("add_op_b", ex_op_b, 32'd7);
    cyc();
    idle(); cyc();
    chk("add_wb_rd", 32'(wb_rd), 32'd3);
    chk("add_wb_rw", 32'(wb_reg_write), 32'd1);
    chk("add_wb_data", wb_data, 32'd12);

    // Forwarding from MEM and WB, and reserved select
    idle(); id_rs_data = 32'h55; id_rt_data = 32'h66; id_ctrl = 9'h102; ex_alu_result = 32'hAB; cyc();
    ex_alu_result = 32'h1234; cyc();
    fwd_a = 2'b10; fwd_b = 2'b01; #1;
    chk("fwd_mem_a", ex_op_a, 32'h1234);
    chk("fwd_wb_b", ex_op_b, 32'hAB);
    chk("fwd_wb_store", ex_store_data, 32'hAB);
    fwd_a = 2'b11; fwd_b = 2'b11; #1;
    chk("fwd_rsv_a", ex_op_a, 32'h55);
    chk("fwd_rsv_b", ex_op_b, 32'h66);
    cyc();

    // Load-use stall for one cycle
    idle(); if_instr = I_LW; cyc();
    idle(); id_ctrl = 9'h1A0; id_rd = 5'd2; if_instr = I_USE; cyc();
    idle(); stall = 1'b1; id_ctrl = 9'h102; ex_alu_result = 32'h40; #1;
    chk("lu_pc_en", 32'(pc_en), 32'h0);
    cyc();
    chk("lu_ifid_hold", ifid_instr, I_USE);
    chk("lu_ex_bubble", 32'(ex_ctrl), 32'h0);
    chk("lu_mem_ctrl", 32'(mem_ctrl), 32'h1A0);
    chk("lu_mem_alu", mem_alu_result, 32'h40);
    stall = 1'b0; cyc();
    chk("lu_reissue", 32'(ex_ctrl), 32'h102);

    // Flush wins over stall
    idle(); if_instr = I_BEQ; cyc();
    idle(); flush = 1'b1; stall = 1'b1; id_ctrl = 9'h1FF; #1;
    chk("fl_pc_en", 32'(pc_en), 32'h1);
    cyc();
    chk("fl_ifid", ifid_instr, 32'h0);
    chk("fl_ex_ctrl", 32'(ex_ctrl), 32'h0);
    idle(); id_ctrl = 9'h1FF; cyc();
    chk("fl_empty_slot", 32'(ex_ctrl), 32'h0);

    // Three-cycle stall
    idle(); if_instr = I_ADDI; cyc();
    idle(); stall = 1'b1; id_ctrl = 9'h113; id_imm = 32'd7;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ls_bubble", 32'(ex_ctrl), 32'h0);
      chk("ls_ifid_hold", ifid_instr, I_ADDI);
    end
    stall = 1'b0; cyc();
    chk("ls_release_ctrl", 32'(ex_ctrl), 32'h113);
    chk("ls_release_imm", ex_op_b, 32'd7);

    // Reset while stalled: held instruction must not re-issue
    idle(); if_instr = I_USE; cyc();
    idle(); stall = 1'b1; id_ctrl = 9'h102; cyc();
    do_reset();
    idle(); id_ctrl = 9'h102; cyc();
    chk("rs_no_reissue", 32'(ex_ctrl), 32'h0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      randomize_inputs();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
